// File: rtl/out_port_tx.sv
// -----------------------------------------------------------------------------
// out_port_tx
//   Consumer end of the core's OUT port. Each 16-bit word written by an OUT
//   instruction is buffered in a small circular FIFO. The word is then sent on a
//   UART TX line as two frames: the high byte first, then the low byte.
//
// Configuration macro:
//   OUT_PORT_PARITY_EN  defined   -> frames are 8E1 (even parity bit before stop)
//                       undefined -> frames are 8N1
//
// Parameters:
//   CLKS_PER_BIT     clock cycles per UART bit (>= 1)
//   FIFO_ADDR_WIDTH  FIFO depth = 2**FIFO_ADDR_WIDTH words
//
// Ports:
//   i_clk       system clock, posedge
//   i_rst_n     asynchronous reset, active-low
//   i_valid     word strobe
//   i_data      word, sampled when i_valid && o_ready
//   o_ready     FIFO not full (registered)
//   o_tx        UART line, idle high (registered)
//   o_busy      frame on the line or FIFO non-empty (registered)
//   o_overflow  sticky: a word was offered while o_ready was low
// -----------------------------------------------------------------------------
module out_port_tx #(
   parameter int CLKS_PER_BIT    = 104,
   parameter int FIFO_ADDR_WIDTH = 2
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_valid,
   input  logic [15:0] i_data,
   output logic        o_ready,
   output logic        o_tx,
   output logic        o_busy,
   output logic        o_overflow
);

   localparam int DEPTH  = 1 << FIFO_ADDR_WIDTH;
   localparam int CNT_W  = FIFO_ADDR_WIDTH + 1;
   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_STOP   = 3'd3;
`ifdef OUT_PORT_PARITY_EN
   localparam logic [2:0] ST_PARITY = 3'd4;

   function automatic logic even_parity(input logic [7:0] b);
      return ^b;
   endfunction
`endif

   logic [2:0]                 state_r, state_nxt_s;
   logic [BAUD_W-1:0]          baud_r, baud_nxt_s;
   logic [2:0]                 bit_idx_r, bit_idx_nxt_s;
   logic                       byte_sel_r, byte_sel_nxt_s;
   logic [15:0]                word_r, word_nxt_s;
   logic [7:0]                 byte_nxt_s;
   logic [15:0]                mem_r [DEPTH];
   logic [FIFO_ADDR_WIDTH-1:0] wr_ptr_r, rd_ptr_r;
   logic [CNT_W-1:0]           count_r, count_nxt_s;
   logic                       push_s, pop_s, baud_done_s, fifo_empty_s;
   logic                       tx_nxt_s, busy_nxt_s;
   logic                       ready_r, tx_r, busy_r, overflow_r;

   assign o_ready    = ready_r;
   assign o_tx       = tx_r;
   assign o_busy     = busy_r;
   assign o_overflow = overflow_r;

   assign baud_done_s  = (baud_r == BAUD_LAST);
   assign fifo_empty_s = (count_r == {CNT_W{1'b0}});
   // ready_r is derived from the count, so a full FIFO refuses a push even when it pops on the same edge
   assign push_s       = i_valid & ready_r;

   // Pop when leaving IDLE, or back-to-back after the second stop bit of a word
   always_comb begin
      pop_s = 1'b0;
      if (state_r == ST_IDLE) begin
         pop_s = ~fifo_empty_s;
      end else if ((state_r == ST_STOP) && baud_done_s && byte_sel_r) begin
         pop_s = ~fifo_empty_s;
      end else begin
         pop_s = 1'b0;
      end
   end

   // FSM state register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (!fifo_empty_s) state_nxt_s = ST_START;
            else               state_nxt_s = ST_IDLE;
         end
         ST_START: begin
            if (baud_done_s) state_nxt_s = ST_DATA;
            else             state_nxt_s = ST_START;
         end
         ST_DATA: begin
            if (baud_done_s && (bit_idx_r == 3'd7)) begin
`ifdef OUT_PORT_PARITY_EN
               state_nxt_s = ST_PARITY;
`else
               state_nxt_s = ST_STOP;
`endif
            end else begin
               state_nxt_s = ST_DATA;
            end
         end
`ifdef OUT_PORT_PARITY_EN
         ST_PARITY: begin
            if (baud_done_s) state_nxt_s = ST_STOP;
            else             state_nxt_s = ST_PARITY;
         end
`endif
         ST_STOP: begin
            if (!baud_done_s)                   state_nxt_s = ST_STOP;
            else if (!byte_sel_r || !fifo_empty_s) state_nxt_s = ST_START;
            else                                state_nxt_s = ST_IDLE;
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Datapath next values: baud counter, bit index, byte select, shift holder, FIFO count
   always_comb begin
      word_nxt_s     = word_r;
      byte_sel_nxt_s = byte_sel_r;
      bit_idx_nxt_s  = bit_idx_r;
      // Every state or bit change lands on baud_done (or leaves IDLE), so this is the reload
      if ((state_r == ST_IDLE) || baud_done_s) baud_nxt_s = {BAUD_W{1'b0}};
      else                                     baud_nxt_s = baud_r + {{(BAUD_W-1){1'b0}}, 1'b1};
      if (pop_s) begin
         word_nxt_s     = mem_r[rd_ptr_r];
         byte_sel_nxt_s = 1'b0;
      end else if ((state_r == ST_STOP) && baud_done_s && !byte_sel_r) begin
         byte_sel_nxt_s = 1'b1;
      end else begin
         byte_sel_nxt_s = byte_sel_r;
      end
      if ((state_r == ST_START) && baud_done_s)     bit_idx_nxt_s = 3'd0;
      else if ((state_r == ST_DATA) && baud_done_s) bit_idx_nxt_s = bit_idx_r + 3'd1;
      else                                          bit_idx_nxt_s = bit_idx_r;
      count_nxt_s = count_r + {{FIFO_ADDR_WIDTH{1'b0}}, push_s}
                            - {{FIFO_ADDR_WIDTH{1'b0}}, pop_s};
   end

   // FSM output logic: line level and busy for the coming cycle
   always_comb begin
      byte_nxt_s = byte_sel_nxt_s ? word_nxt_s[7:0] : word_nxt_s[15:8];
      tx_nxt_s   = 1'b1;
      case (state_nxt_s)
         ST_IDLE:   tx_nxt_s = 1'b1;
         ST_START:  tx_nxt_s = 1'b0;
         ST_DATA:   tx_nxt_s = byte_nxt_s[bit_idx_nxt_s];
`ifdef OUT_PORT_PARITY_EN
         ST_PARITY: tx_nxt_s = even_parity(byte_nxt_s);
`endif
         ST_STOP:   tx_nxt_s = 1'b1;
         default:   tx_nxt_s = 1'b1;
      endcase
      busy_nxt_s = (state_nxt_s != ST_IDLE) || (count_nxt_s != {CNT_W{1'b0}});
   end

   // Datapath registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         baud_r     <= {BAUD_W{1'b0}};
         bit_idx_r  <= 3'd0;
         byte_sel_r <= 1'b0;
         word_r     <= 16'h0000;
      end else begin
         baud_r     <= baud_nxt_s;
         bit_idx_r  <= bit_idx_nxt_s;
         byte_sel_r <= byte_sel_nxt_s;
         word_r     <= word_nxt_s;
      end
   end

   // FIFO storage, pointers and occupancy
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_r[i] <= 16'h0000;
         wr_ptr_r <= {FIFO_ADDR_WIDTH{1'b0}};
         rd_ptr_r <= {FIFO_ADDR_WIDTH{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else begin
         if (push_s) begin
            mem_r[wr_ptr_r] <= i_data;
            wr_ptr_r        <= wr_ptr_r + {{(FIFO_ADDR_WIDTH-1){1'b0}}, 1'b1};
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end
         if (pop_s) rd_ptr_r <= rd_ptr_r + {{(FIFO_ADDR_WIDTH-1){1'b0}}, 1'b1};
         else       rd_ptr_r <= rd_ptr_r;
         count_r <= count_nxt_s;
      end
   end

   // Registered outputs
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ready_r    <= 1'b1;
         tx_r       <= 1'b1;
         busy_r     <= 1'b0;
         overflow_r <= 1'b0;
      end else begin
         ready_r    <= (count_nxt_s != CNT_FULL);
         tx_r       <= tx_nxt_s;
         busy_r     <= busy_nxt_s;
         overflow_r <= overflow_r | (i_valid & ~ready_r);
      end
   end

endmodule
